// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl: loads a weight vector into a single-port BRAM and streams it back out
// through a 2-entry output buffer with full ready/valid backpressure.
module weight_fetch_ctrl #(
   parameter int DEPTH = 28,
   parameter int AW    = 5,
   parameter int DW    = 16
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          START,
   input  logic          MODE,
   output logic          BUSY,
   output logic          DONE,
   input  logic          LD_VALID,
   input  logic [DW-1:0] LD_DATA,
   output logic          LD_READY,
   output logic          W_VALID,
   output logic [DW-1:0] W_DATA,
   output logic          W_LAST,
   input  logic          W_READY,
   output logic [AW-1:0] BR_ADDR,
   output logic [DW-1:0] BR_DI,
   output logic          BR_EN,
   output logic          BR_WE,
   input  logic [DW-1:0] BR_DO
);
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FETCH, S_DRAIN} state_t;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_t state_q, state_d;
   logic [AW-1:0] addr_q, addr_d, br_addr_q, br_addr_d;
   logic [DW-1:0] br_di_q, br_di_d, d0_q, d0_d, d1_q, d1_d;
   logic busy_q, busy_d, done_q, done_d, ld_ready_q, ld_ready_d;
   logic br_en_q, br_en_d, br_we_q, br_we_d;
   logic v0_q, v0_d, l0_q, l0_d, v1_q, v1_d, l1_q, l1_d;
   logic rd_pend, pop, at_last, ld_beat, fe_issue, dr_end;
   logic [1:0] occ;

   assign rd_pend  = br_en_q & ~br_we_q;
   assign pop      = v0_q & W_READY;
   // occupancy after this edge: buffered words minus the pop plus the read landing now
   assign occ      = {1'b0, v0_q} + {1'b0, v1_q} + {1'b0, rd_pend} - {1'b0, pop};
   assign at_last  = addr_q == LAST;
   assign ld_beat  = (state_q == S_LOAD) & LD_VALID & ld_ready_q;
   assign fe_issue = (state_q == S_FETCH) & (occ < 2'd2);
   assign dr_end   = (state_q == S_DRAIN) & pop & l0_q;

   always_ff @(posedge CLK) begin
      if (!RST_N) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (START) state_d = MODE ? S_LOAD : S_FETCH;
         S_LOAD:  if (ld_beat && at_last) state_d = S_IDLE;
         S_FETCH: if (fe_issue && at_last) state_d = S_DRAIN;
         default: if (dr_end) state_d = S_IDLE;
      endcase
   end

   always_comb begin
      addr_d    = addr_q;
      br_en_d   = 1'b0;
      br_we_d   = 1'b0;
      br_addr_d = br_addr_q;
      br_di_d   = br_di_q;
      if (state_q == S_IDLE && START) begin
         br_en_d   = !MODE;
         br_addr_d = '0;
         addr_d    = MODE ? '0 : AW'(1);
      end
      if (ld_beat || fe_issue) begin
         br_en_d   = 1'b1;
         br_we_d   = ld_beat;
         br_addr_d = addr_q;
         addr_d    = at_last ? '0 : addr_q + 1'b1;
      end
      if (ld_beat) br_di_d = LD_DATA;
      busy_d     = state_d != S_IDLE;
      ld_ready_d = state_d == S_LOAD;
      done_d     = (ld_beat & at_last) | dr_end;
      {v0_d, d0_d, l0_d} = pop ? {v1_q, d1_q, l1_q} : {v0_q, d0_q, l0_q};
      {v1_d, d1_d, l1_d} = pop ? {1'b0, d1_q, l1_q} : {v1_q, d1_q, l1_q};
      if (rd_pend && !v0_d) {v0_d, d0_d, l0_d} = {1'b1, BR_DO, br_addr_q == LAST};
      else if (rd_pend)     {v1_d, d1_d, l1_d} = {1'b1, BR_DO, br_addr_q == LAST};
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         addr_q     <= '0;
         br_addr_q  <= '0;
         br_di_q    <= '0;
         br_en_q    <= 1'b0;
         br_we_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ld_ready_q <= 1'b0;
         {v0_q, d0_q, l0_q} <= '0;
         {v1_q, d1_q, l1_q} <= '0;
      end else begin
         addr_q     <= addr_d;
         br_addr_q  <= br_addr_d;
         br_di_q    <= br_di_d;
         br_en_q    <= br_en_d;
         br_we_q    <= br_we_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ld_ready_q <= ld_ready_d;
         {v0_q, d0_q, l0_q} <= {v0_d, d0_d, l0_d};
         {v1_q, d1_q, l1_q} <= {v1_d, d1_d, l1_d};
      end
   end

   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign LD_READY = ld_ready_q;
   assign W_VALID  = v0_q;
   assign W_DATA   = d0_q;
   assign W_LAST   = l0_q;
   assign BR_ADDR  = br_addr_q;
   assign BR_DI    = br_di_q;
   assign BR_EN    = br_en_q;
   assign BR_WE    = br_we_q;
endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// tb_weight_fetch_ctrl: scoreboard bench with a falling-edge BRAM model for weight_fetch_ctrl.
module tb_weight_fetch_ctrl;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
   logic busy, done, ld_valid = 1'b0, ld_ready, w_valid, w_last, w_ready = 1'b0;
   logic br_en, br_we;
   logic [15:0] ld_data = '0, w_data, br_di, br_do = '0;
   logic [4:0] br_addr;
   logic [15:0] mem [28];
   logic [15:0] exp_mem [28];
   logic [16:0] fq [$];
   logic [20:0] wq [$];
   int n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   weight_fetch_ctrl dut (
      .CLK(clk), .RST_N(rst_n), .START(start), .MODE(mode), .BUSY(busy), .DONE(done),
      .LD_VALID(ld_valid), .LD_DATA(ld_data), .LD_READY(ld_ready),
      .W_VALID(w_valid), .W_DATA(w_data), .W_LAST(w_last), .W_READY(w_ready),
      .BR_ADDR(br_addr), .BR_DI(br_di), .BR_EN(br_en), .BR_WE(br_we), .BR_DO(br_do)
   );

   // BRAM samples on the falling edge
   always @(negedge clk) begin
      if (br_en && br_addr < 5'd28) begin
         if (br_we) mem[br_addr] <= br_di;
         else       br_do <= mem[br_addr];
      end
   end

   task automatic test_reset();
      logic saw_en = 1'b0;
      rst_n = 1'b0; start = 1'b1; mode = 1'b1; ld_valid = 1'b1; w_ready = 1'b1; ld_data = 16'hFFFF;
      repeat (3) begin
         @(posedge clk); #1;
         if (br_en) saw_en = 1'b1;
      end
      n_cmp++;
      if ({busy, done, ld_ready, w_valid, w_last, br_en, br_we, br_addr, br_di, w_data} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs got %h required 0",
                  {busy, done, ld_ready, w_valid, w_last, br_en, br_we, br_addr, br_di, w_data});
      end
      n_cmp++;
      if (saw_en !== 1'b0) begin n_err++; $display("FAIL reset_bram_access got %b required 0", saw_en); end
      start = 1'b0; ld_valid = 1'b0; w_ready = 1'b0; rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_release_busy got %b required 0", busy); end
   endtask

   task automatic test_load(input bit gaps, input logic [15:0] base);
      int sent = 0;
      bit fin = 1'b0, beat;
      logic [20:0] w;
      int bad = 0;
      start = 1'b1; mode = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++;
      if ({busy, ld_ready, br_en} !== 3'b110) begin
         n_err++; $display("FAIL load_entry got %b required 110", {busy, ld_ready, br_en});
      end
      for (int c = 0; c < 200 && !fin; c++) begin
         ld_valid = (sent < 28) && (!gaps || (c % 2 == 0));
         ld_data  = base + 16'(sent * 3);
         beat = ld_valid && ld_ready;
         if (beat) begin
            wq.push_back({5'(sent), ld_data});
            exp_mem[sent] = ld_data;
            sent++;
         end
         @(posedge clk); #1;
         ld_valid = 1'b0;
         n_cmp++;
         if (br_en !== beat) begin
            n_err++; $display("FAIL load_en cycle %0d got %b required %b", c, br_en, beat);
         end else if (beat) begin
            w = wq.pop_front();
            n_cmp++;
            if ({br_we, br_addr, br_di} !== {1'b1, w}) begin
               n_err++; $display("FAIL load_write got %h required %h", {br_we, br_addr, br_di}, {1'b1, w});
            end
         end
         n_cmp++;
         if (beat && sent == 28) begin
            fin = 1'b1;
            if ({done, busy, ld_ready} !== 3'b100) begin
               n_err++; $display("FAIL load_done got %b required 100", {done, busy, ld_ready});
            end
         end else if (done !== 1'b0) begin
            n_err++; $display("FAIL load_early_done got %b required 0", done);
         end
      end
      n_cmp++;
      if (!fin) begin n_err++; $display("FAIL load_timeout got %0d beats required 28", sent); end
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0) begin n_err++; $display("FAIL load_done_width got %b required 0", done); end
      for (int i = 0; i < 28; i++) if (mem[i] !== exp_mem[i]) bad++;
      n_cmp++;
      if (bad != 0) begin n_err++; $display("FAIL load_mem_contents got %0d bad words required 0", bad); end
   endtask

   task automatic do_fetch(input int ready_mode, input int abort_at, input bit poke);
      int issued = 1, acc = 0, max_occ = 1;
      bit fin = 1'b0, exp_done = 1'b0, prev_hold = 1'b0, aborted = 1'b0;
      logic [15:0] prev_d;
      logic prev_l;
      logic [16:0] e;
      fq.delete();
      for (int i = 0; i < 28; i++) fq.push_back({i == 27, exp_mem[i]});
      start = 1'b1; mode = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++;
      if ({busy, br_en, br_we, br_addr, w_valid} !== {3'b110, 5'd0, 1'b0}) begin
         n_err++; $display("FAIL fetch_entry got %b required 110000000", {busy, br_en, br_we, br_addr, w_valid});
      end
      for (int c = 0; c < 400 && !fin; c++) begin
         w_ready = (ready_mode == 0) || (c % 5 == 0) || (c % 5 == 3);
         start = poke && (c == 4);
         mode = poke && (c == 4);
         if (w_valid && w_ready) begin
            e = fq.size() > 0 ? fq.pop_front() : 17'h1DEAD;
            n_cmp++;
            if ({w_last, w_data} !== e) begin
               n_err++; $display("FAIL fetch_word %0d got %h required %h", acc, {w_last, w_data}, e);
            end
            acc++;
            if (e[16]) exp_done = 1'b1;
         end
         prev_hold = w_valid && !w_ready; prev_d = w_data; prev_l = w_last;
         @(posedge clk); #1;
         start = 1'b0; mode = 1'b0;
         if (abort_at >= 0 && acc == abort_at) begin
            rst_n = 1'b0;
            repeat (2) begin
               @(posedge clk); #1;
               n_cmp++;
               if (done !== 1'b0) begin n_err++; $display("FAIL abort_done got %b required 0", done); end
            end
            n_cmp++;
            if ({busy, w_valid, br_en, ld_ready} !== 4'b0) begin
               n_err++; $display("FAIL abort_idle got %b required 0000", {busy, w_valid, br_en, ld_ready});
            end
            rst_n = 1'b1;
            @(posedge clk); #1;
            fin = 1'b1; aborted = 1'b1;
            continue;
         end
         n_cmp++;
         if ({br_we, ld_ready} !== 2'b00) begin
            n_err++; $display("FAIL fetch_no_write got %b required 00", {br_we, ld_ready});
         end
         if (prev_hold) begin
            n_cmp++;
            if ({w_valid, w_last, w_data} !== {1'b1, prev_l, prev_d}) begin
               n_err++; $display("FAIL hold_stable got %h required %h", {w_valid, w_last, w_data}, {1'b1, prev_l, prev_d});
            end
         end
         if (br_en) begin
            n_cmp++;
            if (br_addr !== 5'(issued)) begin
               n_err++; $display("FAIL fetch_addr got %0d required %0d", br_addr, issued);
            end
            issued++;
         end
         if (issued - acc > max_occ) max_occ = issued - acc;
         n_cmp++;
         if (exp_done) begin
            fin = 1'b1;
            if ({done, busy, w_valid} !== 3'b100) begin
               n_err++; $display("FAIL fetch_done got %b required 100", {done, busy, w_valid});
            end
            if (ready_mode == 0) begin
               n_cmp++;
               if (c != 28) begin n_err++; $display("FAIL fetch_latency got %0d required 28", c); end
            end
         end else if (done !== 1'b0) begin
            n_err++; $display("FAIL fetch_early_done got %b required 0", done);
         end
      end
      n_cmp++;
      if (!fin) begin n_err++; $display("FAIL fetch_timeout got %0d words required 28", acc); end
      if (!aborted) begin
         n_cmp++;
         if ({32'(issued), 32'(max_occ <= 2), 32'(fq.size())} !== {32'd28, 32'd1, 32'd0}) begin
            n_err++; $display("FAIL fetch_totals got issued %0d occ %0d left %0d required 28 2 0",
                              issued, max_occ, fq.size());
         end
      end
      w_ready = 1'b0;
   endtask

   task automatic test_fetch_stream();  do_fetch(0, -1, 1'b0); endtask
   task automatic test_backpressure();  do_fetch(1, -1, 1'b0); endtask
   task automatic test_start_busy();    do_fetch(1, -1, 1'b1); endtask
   task automatic test_reset_mid();
      do_fetch(0, 11, 1'b0);
      do_fetch(0, -1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_load(1'b0, 16'h0000);
      test_fetch_stream();
      test_backpressure();
      test_load(1'b1, 16'hA5C0);
      test_start_busy();
      test_reset_mid();
      test_backpressure();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
